mc_control: RTL
===============

# mc_control

Multi-cycle main control FSM for the MIPS datapath. Sequences fetch, decode, execute, memory and write-back over the shared single ALU, generating every datapath enable and mux select plus the 4-bit ALU operation code consumed directly by the ALU. Supports R-type add/sub/and/or/slt/nor, lw, sw, beq, j and addi, and stalls on a memory-ready handshake.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; state <- FETCH.
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH completes.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, sampled combinationally in BRANCH.
- mem_ready  in  1  memory completes access this cycle.
- PCWrite  out  1  PC load enable, already combined with the branch condition.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead, MemWrite  out  1 each  memory strobes.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  0 = PC, 1 = A.
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = signext(imm), 11 = signext(imm)<<2.
- ALUop  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RTYPEWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Outputs are Moore-decoded from state; the exceptions are the mem_ready gating and the zero gating below. Unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=ADD, PCSource=00.
  - IRWrite and PCWrite equal mem_ready.
  - Remain in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUop=ADD, which precomputes the branch target into ALUOut.
  - Next state by opcode: 0x00 -> EXEC, 0x23/0x2B -> MEMADR, 0x04 -> BRANCH, 0x02 -> JUMP, 0x08 -> ADDIEX.
  - Any other opcode, or opcode 0x00 with funct outside {0x20,0x22,0x24,0x25,0x2A,0x27}: illegal=1, instr_done=1, next state FETCH, no architectural write.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Next FETCH.
- MEMWR: MemWrite=1, IorD=1. Wait for mem_ready; instr_done=mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUop from funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT, 27 NOR. Next RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCWrite=zero, instr_done=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Next FETCH.

## Timing
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle that mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting, MemRead/MemWrite and IorD are held constant and no other write enable is asserted.
- While reset=1, every write enable (PCWrite, IRWrite, RegWrite, MemWrite, MemRead), instr_done and illegal is forced to 0. The next state after reset is FETCH.
- Reset mid-instruction abandons the instruction; there is no partial write after the reset edge.
- instr_done and illegal never stay high for more than one cycle in non-wait states.

## Structure
- Package mips_ctrl_pkg holds:
  - the state enum;
  - opcode and funct constants;
  - the ALU op encodings, shared with the ALU;
  - the ALUSrcB and PCSource encodings.
- Sub-module alu_decoder (combinational): funct -> 4-bit ALUop plus a legal flag. It is used by both DECODE (legality) and EXEC.
- State register and next-state logic form a single always block; output decode is separate.

## Test plan
- add (op 00, funct 20), mem_ready=1 -> FETCH, DECODE, EXEC (ALUop=0010, ALUSrcA=1, ALUSrcB=00), RTYPEWB (RegWrite=1, RegDst=1); instr_done in cycle 4.
- lw (op 23) with mem_ready low for 2 cycles in MEMRD -> MemRead and IorD=1 held for 3 cycles, MEMWB has RegWrite=1 and MemtoReg=1; 7 cycles total.
- beq (op 04): zero=1 -> PCWrite=1 with PCSource=01 in BRANCH; zero=0 -> PCWrite=0. Both cases take 3 cycles.
- Each funct 20/22/24/25/2A/27 -> ALUop 0010/0110/0000/0001/0111/1100 in EXEC.
- Opcode 0x3F, and R-type with funct 0x00 -> illegal and instr_done pulse in DECODE, no RegWrite or MemWrite, back to FETCH.
- Reset asserted during MEMWR with mem_ready=1 -> MemWrite=0 that cycle; FETCH on the next cycle with all enables 0 until mem_ready.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared encodings for the multi-cycle MIPS control path and ALU.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_st_fetch   = 4'd0;
    localparam state_t c_st_decode  = 4'd1;
    localparam state_t c_st_memadr  = 4'd2;
    localparam state_t c_st_memrd   = 4'd3;
    localparam state_t c_st_memwb   = 4'd4;
    localparam state_t c_st_memwr   = 4'd5;
    localparam state_t c_st_exec    = 4'd6;
    localparam state_t c_st_rtypewb = 4'd7;
    localparam state_t c_st_branch  = 4'd8;
    localparam state_t c_st_jump    = 4'd9;
    localparam state_t c_st_addiex  = 4'd10;
    localparam state_t c_st_addiwb  = 4'd11;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_addi  = 6'h08;

    localparam logic [5:0] c_fn_add = 6'h20;
    localparam logic [5:0] c_fn_sub = 6'h22;
    localparam logic [5:0] c_fn_and = 6'h24;
    localparam logic [5:0] c_fn_or  = 6'h25;
    localparam logic [5:0] c_fn_slt = 6'h2A;
    localparam logic [5:0] c_fn_nor = 6'h27;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t c_alu_and = 4'b0000;
    localparam alu_op_t c_alu_or  = 4'b0001;
    localparam alu_op_t c_alu_add = 4'b0010;
    localparam alu_op_t c_alu_sub = 4'b0110;
    localparam alu_op_t c_alu_slt = 4'b0111;
    localparam alu_op_t c_alu_nor = 4'b1100;

    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : R-type funct field to ALU operation code, with legality flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic       legal
);

    always_comb begin
        aluop = c_alu_add;
        legal = 1'b1;
        case (funct)
            c_fn_add: aluop = c_alu_add;
            c_fn_sub: aluop = c_alu_sub;
            c_fn_and: aluop = c_alu_and;
            c_fn_or:  aluop = c_alu_or;
            c_fn_slt: aluop = c_alu_slt;
            c_fn_nor: aluop = c_alu_nor;
            default:  legal = 1'b0;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS main control FSM driving datapath enables/muxes.
// Revision : 1.0 - initial release
// ============================================================================
module mc_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUop,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    logic [3:0] w_fn_aluop;
    logic       w_fn_legal;
    logic       w_op_illegal;

    alu_decoder u_alu_decoder (
        .funct (funct),
        .aluop (w_fn_aluop),
        .legal (w_fn_legal)
    );

    always_comb begin
        case (opcode)
            c_op_rtype:                    w_op_illegal = !w_fn_legal;
            c_op_lw, c_op_sw, c_op_beq,
            c_op_j, c_op_addi:             w_op_illegal = 1'b0;
            default:                       w_op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            case (r_state)
                c_st_fetch:   if (mem_ready) r_state <= c_st_decode;
                c_st_decode: begin
                    if (w_op_illegal)
                        r_state <= c_st_fetch;
                    else begin
                        case (opcode)
                            c_op_rtype:       r_state <= c_st_exec;
                            c_op_lw, c_op_sw: r_state <= c_st_memadr;
                            c_op_beq:         r_state <= c_st_branch;
                            c_op_j:           r_state <= c_st_jump;
                            default:          r_state <= c_st_addiex;
                        endcase
                    end
                end
                c_st_memadr:  r_state <= (opcode == c_op_lw) ? c_st_memrd : c_st_memwr;
                c_st_memrd:   if (mem_ready) r_state <= c_st_memwb;
                c_st_memwr:   if (mem_ready) r_state <= c_st_fetch;
                c_st_exec:    r_state <= c_st_rtypewb;
                c_st_addiex:  r_state <= c_st_addiwb;
                default:      r_state <= c_st_fetch;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = c_srcb_reg;
        ALUop      = c_alu_and;
        PCSource   = c_pc_alu;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (r_state)
            c_st_fetch: begin
                MemRead = 1'b1;
                ALUSrcB = c_srcb_four;
                ALUop   = c_alu_add;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            c_st_decode: begin
                ALUSrcB    = c_srcb_immsh;
                ALUop      = c_alu_add;
                illegal    = w_op_illegal;
                instr_done = w_op_illegal;
            end
            c_st_memadr, c_st_addiex: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
                ALUop   = c_alu_add;
            end
            c_st_memrd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            c_st_memwb: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            c_st_memwr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            c_st_exec: begin
                ALUSrcA = 1'b1;
                ALUop   = w_fn_aluop;
            end
            c_st_rtypewb: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA    = 1'b1;
                ALUop      = c_alu_sub;
                PCSource   = c_pc_aluout;
                PCWrite    = zero;
                instr_done = 1'b1;
            end
            c_st_jump: begin
                PCWrite    = 1'b1;
                PCSource   = c_pc_jump;
                instr_done = 1'b1;
            end
            c_st_addiwb: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset suppresses every side effect; mux selects are left as decoded.
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            MemRead    = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule : mc_control
`default_nettype wire
